// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running column/line counters with
// sync and blanking flags registered in step with the counters.
module vga_timing #(
  parameter int unsigned HOR_TOTAL       = 1056,
  parameter int unsigned HOR_BLANK_START = 800,
  parameter int unsigned HOR_SYNC_START  = 840,
  parameter int unsigned HOR_SYNC_END    = 968,
  parameter int unsigned VER_TOTAL       = 628,
  parameter int unsigned VER_BLANK_START = 600,
  parameter int unsigned VER_SYNC_START  = 601,
  parameter int unsigned VER_SYNC_END    = 605
) (
  input  logic        pclk,
  input  logic        reset,
  output logic [11:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [11:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
);

  localparam int unsigned CW = 12;
  // One extra bit so that boundaries equal to 4096 still compare correctly.
  localparam int unsigned XW = CW + 1;

  logic [CW-1:0] hcount_nxt;
  logic [CW-1:0] vcount_nxt;
  logic          hwrap;
  logic          vwrap;
  logic [XW-1:0] hx_nxt;
  logic [XW-1:0] vx_nxt;

  // Next counter values; flags are decoded from these so they land with the counts.
  always_comb begin
    hwrap      = (hcount == CW'(HOR_TOTAL - 1));
    vwrap      = (vcount == CW'(VER_TOTAL - 1));
    hcount_nxt = hwrap ? '0 : hcount + CW'(1);
    vcount_nxt = vcount;
    if (hwrap) begin
      vcount_nxt = vwrap ? '0 : vcount + CW'(1);
    end
    hx_nxt = {1'b0, hcount_nxt};
    vx_nxt = {1'b0, vcount_nxt};
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      hblnk       <= (hx_nxt >= XW'(HOR_BLANK_START));
      hsync       <= (hx_nxt >= XW'(HOR_SYNC_START)) && (hx_nxt < XW'(HOR_SYNC_END));
      vblnk       <= (vx_nxt >= XW'(VER_BLANK_START));
      vsync       <= (vx_nxt >= XW'(VER_SYNC_START)) && (vx_nxt < XW'(VER_SYNC_END));
      // Only a genuine frame wrap reaches (0,0) with a pulse; reset release does not.
      frame_start <= hwrap && vwrap;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: reduced-size raster for full-frame coverage plus a
// default-size instance for one real 1056-column line.
module tb_vga_timing;

  localparam int HT  = 40;
  localparam int HBS = 30;
  localparam int HSS = 33;
  localparam int HSE = 37;
  localparam int VT  = 20;
  localparam int VBS = 15;
  localparam int VSS = 16;
  localparam int VSE = 18;
  localparam int FRAME = HT * VT;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] hcount, vcount;
  logic        hsync, hblnk, vsync, vblnk, frame_start;
  logic [11:0] d_hcount, d_vcount;
  logic        d_hsync, d_hblnk, d_vsync, d_vblnk, d_frame_start;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pclk = ~pclk;

  vga_timing #(
    .HOR_TOTAL(HT), .HOR_BLANK_START(HBS), .HOR_SYNC_START(HSS), .HOR_SYNC_END(HSE),
    .VER_TOTAL(VT), .VER_BLANK_START(VBS), .VER_SYNC_START(VSS), .VER_SYNC_END(VSE)
  ) dut (
    .pclk(pclk), .reset(reset), .hcount(hcount), .hsync(hsync), .hblnk(hblnk),
    .vcount(vcount), .vsync(vsync), .vblnk(vblnk), .frame_start(frame_start)
  );

  vga_timing dut_def (
    .pclk(pclk), .reset(reset), .hcount(d_hcount), .hsync(d_hsync), .hblnk(d_hblnk),
    .vcount(d_vcount), .vsync(d_vsync), .vblnk(d_vblnk), .frame_start(d_frame_start)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] pack(input int h, input int v, input bit hs, input bit hb,
                                       input bit vs, input bit vb, input bit fs);
    return {12'(h), 12'(v), hs, hb, vs, vb, fs};
  endfunction

  // Reference model: position p = pixel clocks since reset release.
  int mp = 0;
  bit mvalid = 1'b0;

  always @(posedge pclk) begin
    if (reset) begin
      mp     <= 0;
      mvalid <= 1'b1;
    end else if (mvalid) begin
      mp <= mp + 1;
    end
  end

  always @(negedge pclk) begin
    if (mvalid) begin
      int h, v;
      h = mp % HT;
      v = (mp / HT) % VT;
      chk("model", {hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start},
          pack(h, v, (h >= HSS && h < HSE), (h >= HBS), (v >= VSS && v < VSE), (v >= VBS),
               (mp != 0 && mp % FRAME == 0)));
    end
  end

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge pclk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    int rst_cycles;
    int run;
    int h;
    int v;
    bit hs, hb, vs, vb, fs;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int last_fs, last_hs, nfs, found, cnt;
    bit prev_hs, seen;

    tbl[0]  = '{3, 0,   0,  0,  0, 0, 0, 0, 0};
    tbl[1]  = '{3, 1,   1,  0,  0, 0, 0, 0, 0};
    tbl[2]  = '{3, 2,   2,  0,  0, 0, 0, 0, 0};
    tbl[3]  = '{3, 3,   3,  0,  0, 0, 0, 0, 0};
    tbl[4]  = '{1, 29,  29, 0,  0, 0, 0, 0, 0};
    tbl[5]  = '{2, 30,  30, 0,  0, 1, 0, 0, 0};
    tbl[6]  = '{1, 33,  33, 0,  1, 1, 0, 0, 0};
    tbl[7]  = '{1, 37,  37, 0,  0, 1, 0, 0, 0};
    tbl[8]  = '{2, 39,  39, 0,  0, 1, 0, 0, 0};
    tbl[9]  = '{1, 40,  0,  1,  0, 0, 0, 0, 0};
    tbl[10] = '{1, 600, 0,  15, 0, 0, 0, 1, 0};
    tbl[11] = '{1, 675, 35, 16, 1, 1, 1, 1, 0};
    tbl[12] = '{2, 720, 0,  18, 0, 0, 0, 1, 0};
    tbl[13] = '{1, 800, 0,  0,  0, 0, 0, 0, 1};
    tbl[14] = '{1, 801, 1,  0,  0, 0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      apply_reset(tbl[i].rst_cycles);
      repeat (tbl[i].run) @(posedge pclk);
      @(negedge pclk);
      chk($sformatf("vec%0d", i), {hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start},
          pack(tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].hb, tbl[i].vs, tbl[i].vb, tbl[i].fs));
    end

    // Frame and line periods over three frames.
    apply_reset(2);
    last_fs = -1; last_hs = -1; nfs = 0; prev_hs = 1'b0;
    for (int c = 0; c < 3 * FRAME + 10; c++) begin
      @(negedge pclk);
      if (frame_start) begin
        if (last_fs >= 0) chk("fs_period", c - last_fs, FRAME);
        last_fs = c;
        nfs++;
      end
      if (hsync && !prev_hs) begin
        if (last_hs >= 0) chk("hs_period", c - last_hs, HT);
        last_hs = c;
      end
      prev_hs = hsync;
    end
    chk("fs_count", nfs, 3);

    // Single-cycle reset in the middle of a frame.
    found = 0;
    for (int c = 0; c < 2 * FRAME && found == 0; c++) begin
      @(negedge pclk);
      if (hcount == 12'd20 && vcount == 12'd10) found = 1;
    end
    chk("mid_found", found, 1);
    reset = 1'b1;
    @(posedge pclk);
    #1 reset = 1'b0;
    @(negedge pclk);
    chk("mid_zero", {hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start}, 31'd0);
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < FRAME + 100) begin
      @(negedge pclk);
      cnt++;
      if (frame_start) seen = 1'b1;
    end
    chk("mid_fs_seen", seen, 1);
    chk("mid_fs_delay", cnt, FRAME);

    // One full line of the default 1056-column raster.
    apply_reset(2);
    for (int c = 0; c <= 1056; c++) begin
      @(negedge pclk);
      chk("def_line", {d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_frame_start},
          pack(c % 1056, c / 1056, (c % 1056 >= 840 && c % 1056 < 968), (c % 1056 >= 800),
               0, 0, 0));
    end

    // Randomized reset pulses against the reference model.
    for (int c = 0; c < 20000; c++) begin
      @(posedge pclk);
      #1 reset = ($urandom_range(0, 2999) == 0);
    end
    reset = 1'b0;
    repeat (5) @(posedge pclk);
    @(negedge pclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
